i_cache_pf_ctrl: RTL

Control block for the N-way instruction cache with a degree-N sequential next-line prefetcher. It generalises the single-line prefetch controller: associativity and prefetch depth are parameters, and candidate lines wait in an internal FIFO. Demand misses always pre-empt prefetches. It sits between the CPU fetch port, the I-cache datapath (tag/LRU arrays) and the memory arbiter port.

---
 rtl/i_cache_pf_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/i_cache_pf_ctrl.sv
// N-way I-cache controller with a sequential next-line prefetcher.
// Demand misses pre-empt prefetches; prefetch candidates wait in a small shift FIFO.
//
// state       | meaning
// IDLE        | serve hits, start demand fill or pop a prefetch candidate
// DEMAND_FILL | memory read for a missed fetch line
// PF_FILL     | memory read for a prefetch line; hits still served
module i_cache_pf_ctrl #(
    parameter int WAYS        = 2,
    parameter int LINE_ADDR_W = 27,
    parameter int PF_DEPTH    = 2,
    localparam int WAY_W      = $clog2(WAYS),
    localparam int CNT_W      = $clog2(PF_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_read,
    input  logic [LINE_ADDR_W-1:0] cpu_line_addr,
    output logic                   cpu_resp,
    input  logic                   demand_hit,
    input  logic [WAY_W-1:0]       demand_hit_way,
    input  logic                   pf_enable,
    output logic [LINE_ADDR_W-1:0] pf_probe_addr,
    input  logic                   pf_probe_hit,
    input  logic [WAY_W-1:0]       lru_way,
    output logic                   lru_update,
    output logic [WAY_W-1:0]       lru_touch_way,
    output logic                   mem_read,
    output logic [LINE_ADDR_W-1:0] mem_line_addr,
    input  logic                   mem_resp,
    output logic                   fill_en,
    output logic [WAY_W-1:0]       fill_way,
    output logic [LINE_ADDR_W-1:0] fill_line_addr,
    output logic [CNT_W-1:0]       pf_queue_count
);

    typedef enum logic [1:0] {IDLE, DEMAND_FILL, PF_FILL} state_t;

    state_t                   state_q, state_nxt;
    logic [LINE_ADDR_W-1:0]   fifo_q [PF_DEPTH];
    logic [CNT_W-1:0]         count_q;
    logic                     gen_active_q;
    logic [LINE_ADDR_W-1:0]   pf_base_q;
    logic [CNT_W-1:0]         k_q;

    logic                     fifo_full, demand_miss, hit_ok, pop, push;
    logic                     probing, advance, dup, reload_hit, reload_fill;
    logic [LINE_ADDR_W-1:0]   cand;
    logic [CNT_W-1:0]         wr_idx;

    assign fifo_full   = (count_q == CNT_W'(PF_DEPTH));
    assign demand_miss = (state_q == IDLE) && cpu_read && !demand_hit;
    // Hits are not served in the cycle a line is being written.
    assign hit_ok      = cpu_read && demand_hit &&
                         ((state_q == IDLE) || ((state_q == PF_FILL) && !mem_resp));
    assign pop         = (state_q == IDLE) && !demand_miss && (count_q != '0);
    assign probing     = gen_active_q && pf_enable;
    assign cand        = pf_base_q + LINE_ADDR_W'(k_q);
    assign advance     = probing && !fifo_full;
    assign reload_hit  = hit_ok && (cpu_line_addr != pf_base_q);
    assign reload_fill = (state_q == DEMAND_FILL) && mem_resp;
    assign wr_idx      = pop ? (count_q - CNT_W'(1)) : count_q;

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < PF_DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (fifo_q[i] == cand)) dup = 1'b1;
        end
    end

    assign push = probing && !pf_probe_hit && !dup && !fifo_full && !demand_miss &&
                  !((state_q != IDLE) && (cand == mem_line_addr));

    assign pf_probe_addr  = probing ? cand : '0;
    assign fill_line_addr = mem_line_addr;
    assign pf_queue_count = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt     = state_q;
        cpu_resp      = 1'b0;
        lru_update    = 1'b0;
        lru_touch_way = '0;
        mem_read      = 1'b0;
        fill_en       = 1'b0;
        fill_way      = '0;
        case (state_q)
            IDLE: begin
                if (hit_ok) begin
                    cpu_resp      = 1'b1;
                    lru_update    = 1'b1;
                    lru_touch_way = demand_hit_way;
                end
                if (demand_miss) state_nxt = DEMAND_FILL;
                else if (pop)    state_nxt = PF_FILL;
            end
            DEMAND_FILL: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    fill_en       = 1'b1;
                    fill_way      = lru_way;
                    lru_update    = 1'b1;
                    lru_touch_way = lru_way;
                    state_nxt     = IDLE;
                end
            end
            PF_FILL: begin
                mem_read = 1'b1;
                if (hit_ok) begin
                    cpu_resp      = 1'b1;
                    lru_update    = 1'b1;
                    lru_touch_way = demand_hit_way;
                end
                if (mem_resp) begin
                    fill_en   = 1'b1;
                    fill_way  = lru_way;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO: head at index 0, shifts down on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q       <= '0;
            mem_line_addr <= '0;
            for (int i = 0; i < PF_DEPTH; i++) fifo_q[i] <= '0;
        end else if (demand_miss) begin
            count_q       <= '0;
            mem_line_addr <= cpu_line_addr;
        end else begin
            if (pop) begin
                mem_line_addr <= fifo_q[0];
                for (int i = 0; i < PF_DEPTH - 1; i++) fifo_q[i] <= fifo_q[i+1];
            end
            if (push) begin
                for (int i = 0; i < PF_DEPTH; i++) begin
                    if (CNT_W'(i) == wr_idx) fifo_q[i] <= cand;
                end
            end
            if (pop && !push)      count_q <= count_q - CNT_W'(1);
            else if (push && !pop) count_q <= count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_active_q <= 1'b0;
            pf_base_q    <= '0;
            k_q          <= '0;
        end else if (demand_miss) begin
            gen_active_q <= 1'b0;
        end else if (reload_fill) begin
            gen_active_q <= 1'b1;
            pf_base_q    <= mem_line_addr;
            k_q          <= CNT_W'(1);
        end else if (reload_hit) begin
            gen_active_q <= 1'b1;
            pf_base_q    <= cpu_line_addr;
            k_q          <= CNT_W'(1);
        end else if (advance) begin
            if (k_q == CNT_W'(PF_DEPTH)) gen_active_q <= 1'b0;
            else                         k_q <= k_q + CNT_W'(1);
        end
    end

endmodule
